// File: rtl/id_ex_pipeline_register.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipeline_register
// Description : ID/EX pipeline register with stall, flush and bubble loading.
//               Define ID_EX_BUBBLE_COUNT_EN for the bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipeline_register (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        idValid,
    input  logic [31:0] idPc,
    input  logic [31:0] idRs1Data,
    input  logic [31:0] idRs2Data,
    input  logic [31:0] idImm,
    input  logic [4:0]  idRs1Addr,
    input  logic [4:0]  idRs2Addr,
    input  logic [4:0]  idRd,
    input  logic [2:0]  idFunct3,
    input  logic [3:0]  idAluControl,
    input  logic [1:0]  idInput1Select,
    input  logic [1:0]  idInput2Select,
    input  logic        idRegWrite,
    input  logic        idMemRead,
    input  logic        idMemWrite,
    input  logic        idBranch,
    input  logic        idJump,
    input  logic [1:0]  idMemToReg,
    output logic [31:0] exPc,
    output logic [31:0] exRs1Data,
    output logic [31:0] exRs2Data,
    output logic [31:0] exImm,
    output logic [4:0]  exRs1Addr,
    output logic [4:0]  exRs2Addr,
    output logic [4:0]  exRd,
    output logic [2:0]  exFunct3,
    output logic [3:0]  exAluControl,
    output logic [1:0]  exInput1Select,
    output logic [1:0]  exInput2Select,
    output logic        exRegWrite,
    output logic        exMemRead,
    output logic        exMemWrite,
    output logic        exBranch,
    output logic        exJump,
    output logic [1:0]  exMemToReg,
    output logic        exValid,
    output logic [31:0] bubbleCount
);

    localparam logic [1:0] c_SEL_ZERO     = 2'b10;
    localparam logic [1:0] c_SEL_RESERVED = 2'b11;

    logic        w_load_bubble;
    logic [1:0]  w_sel1;
    logic [1:0]  w_sel2;

    logic [31:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
    logic [4:0]  r_rs1_addr, r_rs2_addr, r_rd;
    logic [2:0]  r_funct3;
    logic [3:0]  r_alu_control;
    logic [1:0]  r_sel1, r_sel2, r_mem_to_reg;
    logic        r_reg_write, r_mem_read, r_mem_write, r_branch, r_jump, r_valid;

    // An empty ID slot is loaded exactly like a flush so it cannot cause side effects.
    assign w_load_bubble = flush | (~stall & ~idValid);
    assign w_sel1 = (idInput1Select == c_SEL_RESERVED) ? c_SEL_ZERO : idInput1Select;
    assign w_sel2 = (idInput2Select == c_SEL_RESERVED) ? c_SEL_ZERO : idInput2Select;

    always_ff @(posedge clk) begin
        if (reset || w_load_bubble) begin
            r_pc          <= '0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_imm         <= '0;
            r_rs1_addr    <= '0;
            r_rs2_addr    <= '0;
            r_rd          <= '0;
            r_funct3      <= '0;
            r_alu_control <= '0;
            r_sel1        <= '0;
            r_sel2        <= '0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_branch      <= 1'b0;
            r_jump        <= 1'b0;
            r_mem_to_reg  <= '0;
            r_valid       <= 1'b0;
        end else if (!stall) begin
            r_pc          <= idPc;
            r_rs1_data    <= idRs1Data;
            r_rs2_data    <= idRs2Data;
            r_imm         <= idImm;
            r_rs1_addr    <= idRs1Addr;
            r_rs2_addr    <= idRs2Addr;
            r_rd          <= idRd;
            r_funct3      <= idFunct3;
            r_alu_control <= idAluControl;
            r_sel1        <= w_sel1;
            r_sel2        <= w_sel2;
            r_reg_write   <= idRegWrite;
            r_mem_read    <= idMemRead;
            r_mem_write   <= idMemWrite;
            r_branch      <= idBranch;
            r_jump        <= idJump;
            r_mem_to_reg  <= idMemToReg;
            r_valid       <= 1'b1;
        end
    end

    assign exPc           = r_pc;
    assign exRs1Data      = r_rs1_data;
    assign exRs2Data      = r_rs2_data;
    assign exImm          = r_imm;
    assign exRs1Addr      = r_rs1_addr;
    assign exRs2Addr      = r_rs2_addr;
    assign exRd           = r_rd;
    assign exFunct3       = r_funct3;
    assign exAluControl   = r_alu_control;
    assign exInput1Select = r_sel1;
    assign exInput2Select = r_sel2;
    assign exRegWrite     = r_reg_write;
    assign exMemRead      = r_mem_read;
    assign exMemWrite     = r_mem_write;
    assign exBranch       = r_branch;
    assign exJump         = r_jump;
    assign exMemToReg     = r_mem_to_reg;
    assign exValid        = r_valid;

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] r_bubble_count;

    // Saturating so a long-running core never wraps the statistic back to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bubble_count <= '0;
        end else if (w_load_bubble && (r_bubble_count != 32'hFFFF_FFFF)) begin
            r_bubble_count <= r_bubble_count + 32'd1;
        end
    end

    assign bubbleCount = r_bubble_count;
`else
    assign bubbleCount = '0;
`endif

endmodule
`default_nettype wire
